pad_cfg_loader: RTL and testbench



---
 rtl/pad_cfg_loader.sv | 136 +++++++++++++
 tb/tb_pad_cfg_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: fetches per-pad config words and shifts them out on the pad serial chain, then strobes load.
// Optional PAD_CFG_AUTOLOAD_EN: a one-shot flag set by reset starts a load as soon as reset releases.
module pad_cfg_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2,
    localparam int IW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1,
    localparam int PW = $clog2(CLK_DIV + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic [IW-1:0]       cfg_index,
    input  logic [CFG_BITS-1:0] cfg_word,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);
    localparam logic [IW-1:0] LAST_PAD = IW'(NUM_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, LOW, HIGH, LOAD, DONE} state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ph;
    logic [BW-1:0]       r_bit;
    logic [CFG_BITS-1:0] r_shift;
    logic [IW-1:0]       r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_sclk;
    logic                r_sdata;
    logic                r_sload;
    logic                w_start;
    logic                w_ph_end;
    logic                w_word_end;

`ifdef PAD_CFG_AUTOLOAD_EN
    logic r_auto;
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_auto <= 1'b1;
        else if (r_state == IDLE)
            r_auto <= 1'b0;
    end
    assign w_start = start | r_auto;
`else
    assign w_start = start;
`endif

    assign w_ph_end   = (r_ph == LAST_PH);
    assign w_word_end = (r_bit == LAST_BIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_ph    <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_idx   <= LAST_PAD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_sdata <= 1'b0;
            r_sload <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= LOW;
                        r_busy  <= 1'b1;
                        r_ph    <= '0;
                        r_bit   <= '0;
                        r_idx   <= LAST_PAD;
                    end
                end
                LOW: begin
                    // cfg_word is only trusted on the first low cycle of a word's first bit
                    if (r_ph == '0) begin
                        r_sdata <= (r_bit == '0) ? cfg_word[CFG_BITS-1] : r_shift[CFG_BITS-1];
                        if (r_bit == '0)
                            r_shift <= cfg_word;
                    end
                    r_ph <= w_ph_end ? '0 : r_ph + 1'b1;
                    if (w_ph_end) begin
                        r_state <= HIGH;
                        r_sclk  <= 1'b1;
                    end
                end
                HIGH: begin
                    r_ph <= w_ph_end ? '0 : r_ph + 1'b1;
                    if (w_ph_end) begin
                        r_shift <= r_shift << 1;
                        r_sclk  <= 1'b0;
                        r_bit   <= w_word_end ? '0 : r_bit + 1'b1;
                        if (w_word_end && r_idx == '0) begin
                            r_state <= LOAD;
                            r_sload <= 1'b1;
                            r_sdata <= 1'b0;
                        end else begin
                            r_state <= LOW;
                            if (w_word_end)
                                r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                LOAD: begin
                    r_ph <= w_ph_end ? '0 : r_ph + 1'b1;
                    if (w_ph_end) begin
                        r_state <= DONE;
                        r_sload <= 1'b0;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= LAST_PAD;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_index    = r_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign serial_clock = r_sclk;
    assign serial_data  = r_sdata;
    assign serial_load  = r_sload;
endmodule

// File: tb/tb_pad_cfg_loader.sv
// tb_pad_cfg_loader: scoreboard bench for pad_cfg_loader (2 pads x 3 bits, CLK_DIV=1 and CLK_DIV=3).
module tb_pad_cfg_loader;
    logic       clock = 1'b0;
    logic       reset_a, reset_b, start_a, start_b;
    logic [2:0] w1, w0;
    logic       idx_a, busy_a, done_a, sclk_a, sdata_a, sload_a;
    logic       idx_b, busy_b, done_b, sclk_b, sdata_b, sload_b;
    logic [2:0] word_a, word_b;
    int         n_total = 0, n_bad = 0;
    int         cyc = 0, t0 = 0, done_cnt = 0, last_done = 0, dcnt_b = 0;
    logic       prev_busy = 1'b0, prev_sclk = 1'b0;
    logic       exp_bits[$];
    int         exp_lat[$];

    always #5 clock = ~clock;

    assign word_a = idx_a ? w1 : w0;
    assign word_b = idx_b ? w1 : w0;

    pad_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) dut_a (
        .clock(clock), .reset(reset_a), .start(start_a), .cfg_index(idx_a), .cfg_word(word_a),
        .busy(busy_a), .done(done_a), .serial_clock(sclk_a), .serial_data(sdata_a), .serial_load(sload_a));

    pad_cfg_loader #(.NUM_PADS(2), .CFG_BITS(3), .CLK_DIV(3)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .cfg_index(idx_b), .cfg_word(word_b),
        .busy(busy_b), .done(done_b), .serial_clock(sclk_b), .serial_data(sdata_b), .serial_load(sload_b));

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    task automatic expect_load();
        for (int b = 2; b >= 0; b--) exp_bits.push_back(w1[b]);
        for (int b = 2; b >= 0; b--) exp_bits.push_back(w0[b]);
        exp_lat.push_back(13);
    endtask

    task automatic pulse_a();
        @(negedge clock) start_a = 1'b1;
        @(negedge clock) start_a = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 300) begin
            @(posedge clock);
            t++;
        end
        chk("done_count", done_cnt, target);
    endtask

    task automatic check_reset_a(input string tag);
        chk({tag, "_cfg_index"}, idx_a, 1);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_sclk"}, sclk_a, 0);
        chk({tag, "_sdata"}, sdata_a, 0);
        chk({tag, "_sload"}, sload_a, 0);
    endtask

    task automatic post_reset_a();
`ifdef PAD_CFG_AUTOLOAD_EN
        int target = done_cnt + 1;
        expect_load();
        @(negedge clock);
        chk("autoload_busy", busy_a, 1);
        wait_done(target);
`else
        repeat (4) begin
            @(negedge clock);
            chk("idle_busy", busy_a, 0);
        end
`endif
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) if (done_b) dcnt_b <= dcnt_b + 1;

    // monitor: compares whatever DUT A presents against the queued expectations
    always @(negedge clock) begin
        if (reset_a) begin
            prev_busy = 1'b0;
            prev_sclk = 1'b0;
        end else begin
            if (busy_a && !prev_busy) t0 = cyc;
            if (busy_a) chk("cfg_index", idx_a, (cyc - t0) < 6 ? 1 : 0);
            if (sclk_a && !prev_sclk) begin
                if (exp_bits.size() == 0) fail_now("serial_bit");
                else chk("serial_data", sdata_a, exp_bits.pop_front());
            end
            if (sload_a) begin
                if (exp_lat.size() == 0) fail_now("serial_load");
                else chk("load_cycle", cyc - t0, exp_lat[0] - 1);
            end
            if (done_a) begin
                done_cnt++;
                last_done = cyc;
                if (exp_lat.size() == 0) fail_now("done");
                else chk("done_cycle", cyc - t0, exp_lat.pop_front());
            end
            prev_busy = busy_a;
            prev_sclk = sclk_a;
        end
    end

    task automatic run_b();
        int hi_run = 0, lo_run = 0, hi_bad = 0, lo_bad = 0, nbits = 0;
        int load_first = -1, load_cnt = 0, done_idx = -1, data_chg = 0;
        logic [5:0] bits = '0;
        logic [5:0] want;
        logic ps = 1'b0, pd = 1'b0;
        want = {w1, w0};
        @(negedge clock) start_b = 1'b1;
        @(negedge clock) start_b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sclk_b && !ps) begin
                bits = {bits[4:0], sdata_b};
                nbits++;
                if (lo_run != 3) lo_bad++;
                lo_run = 0;
            end
            if (sclk_b && ps && sdata_b != pd) data_chg++;
            if (sclk_b) hi_run++;
            else begin
                if (ps && hi_run != 3) hi_bad++;
                if (ps) hi_run = 0;
                if (busy_b && !sload_b) lo_run++;
            end
            if (sload_b) begin
                if (load_first < 0) load_first = i;
                load_cnt++;
            end
            if (done_b && done_idx < 0) done_idx = i;
            ps = sclk_b;
            pd = sdata_b;
            @(negedge clock);
        end
        chk("b_nbits", nbits, 6);
        chk("b_bits", bits, want);
        chk("b_high_len_bad", hi_bad, 0);
        chk("b_low_len_bad", lo_bad, 0);
        chk("b_data_change_in_high", data_chg, 0);
        chk("b_load_first", load_first, 36);
        chk("b_load_width", load_cnt, 3);
        chk("b_done_cycle", done_idx, 39);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, d1;
        w1 = 3'b101;
        w0 = 3'b011;
        start_a = 1'b0;
        start_b = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        #1;
        check_reset_a("rst");
        chk("rst_b_cfg_index", idx_b, 1);
        chk("rst_b_busy", busy_b, 0);
        repeat (3) @(negedge clock);
        reset_a = 1'b0;
        reset_b = 1'b0;
        post_reset_a();
`ifdef PAD_CFG_AUTOLOAD_EN
        for (int t = 0; t < 100 && dcnt_b == 0; t++) @(posedge clock);
        chk("b_autoload_done", dcnt_b, 1);
`endif
        // basic load with a start pulse during busy that must be ignored
        base = done_cnt;
        expect_load();
        pulse_a();
        repeat (3) @(negedge clock);
        start_a = 1'b1;
        @(negedge clock) start_a = 1'b0;
        wait_done(base + 1);
        repeat (20) @(posedge clock);
        chk("no_queued_start", done_cnt, base + 1);
        // start held high through done: back-to-back loads
        w1 = 3'b110;
        w0 = 3'b001;
        base = done_cnt;
        expect_load();
        expect_load();
        @(negedge clock) start_a = 1'b1;
        wait_done(base + 1);
        d1 = last_done;
        @(negedge clock);
        @(negedge clock) start_a = 1'b0;
        wait_done(base + 2);
        chk("back_to_back_gap", last_done - d1, 15);
        repeat (5) @(posedge clock);
        chk("hold_two_dones", done_cnt, base + 2);
        // reset in the 5th high phase
        w1 = 3'b101;
        w0 = 3'b011;
        expect_load();
        pulse_a();
        repeat (9) @(negedge clock);
        chk("pre_reset_sclk", sclk_a, 1);
        #1 reset_a = 1'b1;
        #1;
        check_reset_a("mid_rst");
        exp_bits.delete();
        exp_lat.delete();
        repeat (2) @(negedge clock);
        reset_a = 1'b0;
        post_reset_a();
        base = done_cnt;
        expect_load();
        pulse_a();
        wait_done(base + 1);
        // pad1 word changes after its capture cycle
        base = done_cnt;
        expect_load();
        pulse_a();
        @(negedge clock) w1 = 3'b000;
        wait_done(base + 1);
        w1 = 3'b101;
        repeat (3) @(posedge clock);
        run_b();
        chk("bits_left", exp_bits.size(), 0);
        chk("lat_left", exp_lat.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
